muldiv_hilo_unit: RTL
=====================

Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO architectural registers of the ARC MIPS core.
- Sits directly downstream of the register bank. It consumes the Rs/Rt read data for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Feeds HI/LO back toward the writeback path for MFHI/MFLO.
- Multi-cycle. o_busy stalls the pipeline while an operation is in flight.

Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is supported.
- CNT_W, 5, iteration counter width (log2 DATA_W).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  one-cycle request to begin an operation.
- i_op  input  2  md_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- i_data_Rs  input  32  operand A (multiplicand / dividend); also MTHI/MTLO data.
- i_data_Rt  input  32  operand B (multiplier / divisor).
- i_wr_hi  input  1  MTHI strobe: HI <= i_data_Rs.
- i_wr_lo  input  1  MTLO strobe: LO <= i_data_Rs.
- o_busy  output  1  high while an operation is in flight.
- o_done  output  1  one-cycle pulse when HI/LO have just been updated by an operation.
- o_hi  output  32  current HI register.
- o_lo  output  32  current LO register.

Behaviour:
- Reset (async, any state): FSM to IDLE; HI=0, LO=0, counter=0, o_busy=0, o_done=0.
- FSM states:
  - IDLE: o_busy=0. At an edge with i_start=1, capture operands and go to CALC, counter=0.
    - Signed ops capture magnitudes plus sign flags; unsigned ops capture raw values.
  - CALC: o_busy=1. One iteration per edge.
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract (remainder/quotient).
    - 32 iterations. At the edge where counter==31, go to FIX.
  - FIX: o_busy=1. Apply sign fixup, write HI/LO at this edge, go to IDLE, set o_done=1.
- Latency: start accepted at edge E0. Iterations run at E1..E32. HI/LO are written at E33. o_done=1 and the new o_hi/o_lo are visible in the cycle after E33. o_busy is high for exactly 33 cycles.
- o_done is registered and clears at the next edge.
- Multiply results: HI = product[63:32], LO = product[31:0].
  - MULT: product negated (64-bit two's complement) iff the operand signs differ.
- Divide results: LO = quotient, HI = remainder.
  - DIV: quotient truncates toward zero; negated iff the operand signs differ.
  - DIV: remainder takes the sign of the dividend.
  - -2^31 / -1 gives LO=0x80000000, HI=0 (no trap).
- Divide by zero (DIV or DIVU, i_data_Rt==0): still takes the full 33 cycles. Result LO=0xFFFFFFFF, HI=captured i_data_Rs unchanged. Sign fixup is skipped.
- i_start while o_busy=1: ignored, no re-capture.
- i_wr_hi / i_wr_lo:
  - Honoured only in IDLE, at the edge they are sampled; both may be set together.
  - Ignored while busy.
  - If i_start and i_wr_* are set in the same IDLE cycle, i_start wins and the write is dropped.
- o_hi/o_lo are driven directly from the registers. They hold their old values throughout CALC/FIX.
- Reset mid-operation aborts the operation: no o_done, HI/LO=0.

Decomposition:
- Package arc_pkg holds:
  - typedef enum logic [1:0] md_op_t {MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3};
  - typedef enum logic [1:0] md_state_t {MD_IDLE, MD_CALC, MD_FIX};
  - localparam MD_ITER = 32.
- One natural sub-module: md_sign_fix, the combinational magnitude/negate helper used at capture and in FIX. The FSM, counter and datapath stay in the top module.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. o_busy high for 33 cycles; o_done pulses exactly once, in the cycle after E33.
- MULT -3 x 5 (0xFFFFFFFD, 0x00000005) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064.
- Mid-operation events:
  - MTHI 0x1234 in IDLE -> o_hi=0x1234 next cycle.
  - MULTU 2 x 3 started with a second i_start and i_wr_lo pulsed at cycle 10 -> both ignored; result HI=0, LO=6.
  - Repeat the MULTU 2 x 3 and assert i_rst at cycle 20 -> HI=LO=0, o_busy=0 immediately, no o_done.

Source files
------------

// File: rtl/arc_pkg.sv
// Shared types and constants for the ARC multiply/divide HI/LO unit.
package arc_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_CALC,
      MD_FIX
   } md_state_t;

   localparam int MD_ITER = 32;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: yields magnitudes at capture and applies sign fixup.
// Purely combinational, no flow control.
module md_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? ((~i_val) + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; results land 33 edges after start.
// o_busy covers the whole operation; starts and MTHI/MTLO arriving while busy are dropped.
module muldiv_hilo_unit
   import arc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [1:0]        i_op,
   input  logic [DATA_W-1:0] i_data_Rs,
   input  logic [DATA_W-1:0] i_data_Rt,
   input  logic              i_wr_hi,
   input  logic              i_wr_lo,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MD_ITER - 1);

   md_state_t            state_q;
   md_op_t               op_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*DATA_W-1:0]  acc_q;
   logic [DATA_W-1:0]    opnd_q;
   logic [DATA_W-1:0]    rs_q;
   logic                 neg_q;
   logic                 rem_neg_q;
   logic                 dz_q;
   logic [DATA_W-1:0]    hi_q;
   logic [DATA_W-1:0]    lo_q;
   logic                 busy_q;
   logic                 done_q;

   logic                 in_signed;
   logic                 in_div;
   logic [DATA_W-1:0]    rs_mag;
   logic [DATA_W-1:0]    rt_mag;
   logic [DATA_W:0]      mul_sum;
   logic [2*DATA_W-1:0]  mul_d;
   logic [DATA_W:0]      rem_sh;
   logic [DATA_W+1:0]    div_diff;
   logic [2*DATA_W-1:0]  div_d;
   logic [2*DATA_W-1:0]  prod_fix;
   logic [DATA_W-1:0]    quo_fix;
   logic [DATA_W-1:0]    rem_fix;

   assign in_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
   assign in_div    = i_op[1];

   md_sign_fix #(.W(DATA_W)) u_mag_rs (
      .i_val (i_data_Rs),
      .i_neg (in_signed & i_data_Rs[DATA_W-1]),
      .o_val (rs_mag)
   );

   md_sign_fix #(.W(DATA_W)) u_mag_rt (
      .i_val (i_data_Rt),
      .i_neg (in_signed & i_data_Rt[DATA_W-1]),
      .o_val (rt_mag)
   );

   // Multiply: acc holds {partial high, remaining multiplier bits}; add then shift right.
   assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                  + {1'b0, (acc_q[0] ? opnd_q : {DATA_W{1'b0}})};
   assign mul_d   = {mul_sum, acc_q[DATA_W-1:1]};

   // Divide: acc holds {remainder, dividend/quotient}; restoring shift-subtract.
   assign rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
   assign div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
   assign div_d    = div_diff[DATA_W+1]
                   ? {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                   : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

   md_sign_fix #(.W(2*DATA_W)) u_fix_prod (
      .i_val (acc_q),
      .i_neg (neg_q),
      .o_val (prod_fix)
   );

   md_sign_fix #(.W(DATA_W)) u_fix_quo (
      .i_val (acc_q[DATA_W-1:0]),
      .i_neg (neg_q),
      .o_val (quo_fix)
   );

   md_sign_fix #(.W(DATA_W)) u_fix_rem (
      .i_val (acc_q[2*DATA_W-1:DATA_W]),
      .i_neg (rem_neg_q),
      .o_val (rem_fix)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= MD_IDLE;
         op_q      <= MD_MULT;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         rs_q      <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            MD_IDLE: begin
               if (i_start) begin
                  op_q      <= md_op_t'(i_op);
                  rs_q      <= i_data_Rs;
                  neg_q     <= in_signed & (i_data_Rs[DATA_W-1] ^ i_data_Rt[DATA_W-1]);
                  rem_neg_q <= in_signed & in_div & i_data_Rs[DATA_W-1];
                  dz_q      <= in_div & (i_data_Rt == '0);
                  opnd_q    <= in_div ? rt_mag : rs_mag;
                  acc_q     <= {{DATA_W{1'b0}}, (in_div ? rs_mag : rt_mag)};
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= MD_CALC;
               end else begin
                  if (i_wr_hi) hi_q <= i_data_Rs;
                  if (i_wr_lo) lo_q <= i_data_Rs;
               end
            end
            MD_CALC: begin
               acc_q <= op_q[1] ? div_d : mul_d;
               if (cnt_q == LAST_ITER) begin
                  state_q <= MD_FIX;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            MD_FIX: begin
               if (!op_q[1]) begin
                  hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                  lo_q <= prod_fix[DATA_W-1:0];
               end else if (dz_q) begin
                  hi_q <= rs_q;
                  lo_q <= {DATA_W{1'b1}};
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= MD_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= MD_IDLE;
            end
         endcase
      end
   end

   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_hi   = hi_q;
   assign o_lo   = lo_q;

endmodule
